// File: rtl/gfx_text_sequencer.sv
// rtl/gfx_text_sequencer.sv - walks a 16-bit character string in 64-bit memory words and issues one blit request per glyph
// Define GFX_TEXTSEQ_NEWLINE_EN to turn code 16'h000A into a carriage return plus line feed.
module gfx_text_sequencer #(
  parameter int point_width = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [31:0]            str_adr_i,
  input  logic [15:0]            str_len_i,
  input  logic [point_width-1:0] pos_x_i,
  input  logic [point_width-1:0] pos_y_i,
  input  logic [point_width-1:0] adv_x_i,
  input  logic [point_width-1:0] adv_y_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   read_request_o,
  output logic [7:0]             seq_sel_o,
  output logic [31:0]            seq_adr_o,
  input  logic                   seq_ack_i,
  input  logic [63:0]            seq_dat_i,
  output logic                   char_o,
  output logic [15:0]            char_code_o,
  output logic [point_width-1:0] char_pos_x_o,
  output logic [point_width-1:0] char_pos_y_o,
  input  logic                   char_ack_i
);

  typedef enum logic [2:0] {IDLE, FETCH, FETCH_ACK, ISSUE, WAIT_CHAR, DONE} state_t;

  state_t                 state;
  logic [31:0]            word_adr;
  logic [1:0]             lane;
  logic [15:0]            remaining;
  logic [63:0]            word;
  logic [point_width-1:0] cur_x;
  logic [point_width-1:0] cur_y;
  logic [point_width-1:0] org_x;
  logic [point_width-1:0] step_x;
  logic [15:0]            code;
  logic                   last;
  logic                   wrap;
  logic [31:0]            next_adr;
  logic                   unused_adr0;

  assign code        = word[{lane, 4'b0000} +: 16];
  assign last        = (remaining == 16'd1);
  assign wrap        = (lane == 2'd3);
  assign next_adr    = word_adr + 32'd8;
  assign unused_adr0 = str_adr_i[0];

`ifdef GFX_TEXTSEQ_NEWLINE_EN
  logic [point_width-1:0] step_y;
`else
  logic unused_adv_y;
  assign unused_adv_y = ^adv_y_i;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= IDLE;
      word_adr       <= '0;
      lane           <= '0;
      remaining      <= '0;
      word           <= '0;
      cur_x          <= '0;
      cur_y          <= '0;
      org_x          <= '0;
      step_x         <= '0;
`ifdef GFX_TEXTSEQ_NEWLINE_EN
      step_y         <= '0;
`endif
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      read_request_o <= 1'b0;
      seq_sel_o      <= '0;
      seq_adr_o      <= '0;
      char_o         <= 1'b0;
      char_code_o    <= '0;
      char_pos_x_o   <= '0;
      char_pos_y_o   <= '0;
    end else begin
      done_o <= 1'b0;
      char_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            busy_o <= 1'b1;
            if (str_len_i == 16'd0) begin
              state <= DONE;
            end else begin
              word_adr       <= {str_adr_i[31:3], 3'b000};
              lane           <= str_adr_i[2:1];
              remaining      <= str_len_i;
              cur_x          <= pos_x_i;
              cur_y          <= pos_y_i;
              org_x          <= pos_x_i;
              step_x         <= adv_x_i;
`ifdef GFX_TEXTSEQ_NEWLINE_EN
              step_y         <= adv_y_i;
`endif
              // Request is raised on entry so it is visible the cycle after start.
              read_request_o <= 1'b1;
              seq_sel_o      <= 8'hFF;
              seq_adr_o      <= {str_adr_i[31:3], 3'b000};
              state          <= FETCH;
            end
          end
        end
        FETCH: state <= FETCH_ACK;
        FETCH_ACK: begin
          if (seq_ack_i) begin
            word           <= seq_dat_i;
            read_request_o <= 1'b0;
            state          <= ISSUE;
          end
        end
        ISSUE: begin
`ifdef GFX_TEXTSEQ_NEWLINE_EN
          if (code == 16'h000A) begin
            cur_x     <= org_x;
            cur_y     <= cur_y + step_y;
            remaining <= remaining - 16'd1;
            lane      <= lane + 2'd1;
            if (last) begin
              state <= DONE;
            end else if (wrap) begin
              word_adr       <= next_adr;
              read_request_o <= 1'b1;
              seq_adr_o      <= next_adr;
              state          <= FETCH;
            end else begin
              state <= ISSUE;
            end
          end else
`endif
          begin
            char_o       <= 1'b1;
            char_code_o  <= code;
            char_pos_x_o <= cur_x;
            char_pos_y_o <= cur_y;
            state        <= WAIT_CHAR;
          end
        end
        WAIT_CHAR: begin
          if (char_ack_i) begin
            cur_x     <= cur_x + step_x;
            remaining <= remaining - 16'd1;
            lane      <= lane + 2'd1;
            if (last) begin
              state <= DONE;
            end else if (wrap) begin
              word_adr       <= next_adr;
              read_request_o <= 1'b1;
              seq_adr_o      <= next_adr;
              state          <= FETCH;
            end else begin
              state <= ISSUE;
            end
          end
        end
        DONE: begin
          done_o <= 1'b1;
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gfx_text_sequencer.sv
// tb/tb_gfx_text_sequencer.sv - scoreboard bench with memory and blitter responders for gfx_text_sequencer
module tb_gfx_text_sequencer;

  typedef struct {
    logic [15:0] code;
    logic [15:0] x;
    logic [15:0] y;
  } glyph_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] str_adr;
  logic [15:0] str_len;
  logic [15:0] pos_x, pos_y, adv_x, adv_y;
  logic        busy, done;
  logic        read_request;
  logic [7:0]  seq_sel;
  logic [31:0] seq_adr;
  logic        seq_ack;
  logic [63:0] seq_dat;
  logic        char_v;
  logic [15:0] char_code;
  logic [15:0] char_pos_x, char_pos_y;
  logic        char_ack;

  int total = 0;
  int bad = 0;
  int char_cnt = 0;
  int done_cnt = 0;
  int fetch_cnt = 0;
  int req_cycles = 0;
  int mem_delay = 1;
  int blit_delay = 0;
  bit adr_moved = 0;
  bit hold_err = 0;

  logic [63:0] mem [logic [31:0]];
  glyph_t      exp_q[$];
  logic [31:0] fetch_q[$];

  gfx_text_sequencer #(.point_width(16)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .str_adr_i(str_adr), .str_len_i(str_len),
    .pos_x_i(pos_x), .pos_y_i(pos_y), .adv_x_i(adv_x), .adv_y_i(adv_y),
    .busy_o(busy), .done_o(done),
    .read_request_o(read_request), .seq_sel_o(seq_sel), .seq_adr_o(seq_adr),
    .seq_ack_i(seq_ack), .seq_dat_i(seq_dat),
    .char_o(char_v), .char_code_o(char_code),
    .char_pos_x_o(char_pos_x), .char_pos_y_o(char_pos_y), .char_ack_i(char_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: acks after mem_delay cycles of FETCH_ACK, checks the address against the expected fetch list.
  initial begin : mem_responder
    int cnt;
    logic [31:0] first_adr;
    logic [31:0] e_adr;
    cnt = 0;
    first_adr = '0;
    seq_ack = 1'b0;
    seq_dat = '0;
    forever begin
      @(negedge clk);
      if (seq_ack) begin
        seq_ack = 1'b0;
        cnt = 0;
      end else if (read_request === 1'b1) begin
        req_cycles++;
        cnt++;
        if (cnt == 1) first_adr = seq_adr;
        else if (seq_adr !== first_adr) adr_moved = 1'b1;
        if (cnt >= mem_delay + 1) begin
          seq_ack = 1'b1;
          seq_dat = mem.exists(seq_adr) ? mem[seq_adr] : 64'd0;
          fetch_cnt++;
          total++;
          if (fetch_q.size() == 0) begin
            bad++;
            $display("FAIL fetch_unexpected: got adr %08h required none", seq_adr);
          end else begin
            e_adr = fetch_q.pop_front();
            if ({seq_sel, seq_adr} !== {8'hFF, e_adr}) begin
              bad++;
              $display("FAIL fetch_adr: got sel %02h adr %08h required sel ff adr %08h", seq_sel, seq_adr, e_adr);
            end
          end
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Blitter: scoreboards each char_o pulse, acks after blit_delay cycles, watches outputs stay held.
  initial begin : blit_responder
    int cd;
    bit pending;
    glyph_t e;
    logic [47:0] cap;
    cd = 0;
    pending = 0;
    cap = '0;
    char_ack = 1'b0;
    forever begin
      @(negedge clk);
      char_ack = 1'b0;
      if (char_v === 1'b1) begin
        char_cnt++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL char_unexpected: got code %04h at (%0h,%0h) required none", char_code, char_pos_x, char_pos_y);
        end else begin
          e = exp_q.pop_front();
          if ({char_code, char_pos_x, char_pos_y} !== {e.code, e.x, e.y}) begin
            bad++;
            $display("FAIL char_glyph: got code %04h at (%0h,%0h) required code %04h at (%0h,%0h)",
                     char_code, char_pos_x, char_pos_y, e.code, e.x, e.y);
          end
        end
        pending = 1;
        cd = blit_delay;
        cap = {char_code, char_pos_x, char_pos_y};
      end else if (pending && busy === 1'b1 && {char_code, char_pos_x, char_pos_y} !== cap) begin
        hold_err = 1'b1;
      end
      if (pending) begin
        if (cd == 0) begin
          char_ack = 1'b1;
          pending = 0;
        end else begin
          cd--;
        end
      end
    end
  end

  initial begin : done_monitor
    forever begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
    end
  end

  task automatic start_string(input logic [31:0] adr, input logic [15:0] len,
                              input logic [15:0] x, input logic [15:0] y,
                              input logic [15:0] ax, input logic [15:0] ay);
    @(negedge clk);
    str_adr = adr; str_len = len; pos_x = x; pos_y = y; adv_x = ax; adv_y = ay;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic push_glyph(input logic [15:0] code, input logic [15:0] x, input logic [15:0] y);
    glyph_t g;
    g.code = code; g.x = x; g.y = y;
    exp_q.push_back(g);
  endtask

  task automatic wait_done(input int budget);
    int base;
    base = done_cnt;
    for (int i = 0; i < budget && done_cnt == base; i++) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    total++;
    if ({busy, done, read_request, char_v} !== 4'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got %b required 0000", {busy, done, read_request, char_v});
    end
    total++;
    if ({seq_sel, seq_adr} !== 40'd0) begin
      bad++;
      $display("FAIL reset_mem: got sel %02h adr %08h required 0", seq_sel, seq_adr);
    end
    total++;
    if ({char_code, char_pos_x, char_pos_y} !== 48'd0) begin
      bad++;
      $display("FAIL reset_char: got %012h required 0", {char_code, char_pos_x, char_pos_y});
    end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    int c0, f0, d0;
    c0 = char_cnt; f0 = fetch_cnt; d0 = done_cnt;
    mem[32'h1000] = 64'h0000_0043_0042_0041;
    push_glyph(16'h41, 16'd10, 16'd20);
    push_glyph(16'h42, 16'd18, 16'd20);
    push_glyph(16'h43, 16'd26, 16'd20);
    fetch_q.push_back(32'h1000);
    mem_delay = 1; blit_delay = 0;
    start_string(32'h1000, 16'd3, 16'd10, 16'd20, 16'd8, 16'd0);
    #1;
    total++;
    if ({read_request, busy} !== 2'b11) begin
      bad++;
      $display("FAIL basic_req_latency: got req %b busy %b required 1 1", read_request, busy);
    end
    wait_done(200);
    @(negedge clk); #1;
    total++;
    if (char_cnt - c0 != 3 || fetch_cnt - f0 != 1 || done_cnt - d0 != 1) begin
      bad++;
      $display("FAIL basic_counts: got chars %0d fetches %0d dones %0d required 3 1 1", char_cnt - c0, fetch_cnt - f0, done_cnt - d0);
    end
    total++;
    if (exp_q.size() != 0 || fetch_q.size() != 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL basic_drain: got glyphs left %0d fetches left %0d busy %b required 0 0 0", exp_q.size(), fetch_q.size(), busy);
    end
  endtask

  task automatic test_lane_wrap;
    int c0, f0, d0;
    c0 = char_cnt; f0 = fetch_cnt; d0 = done_cnt;
    mem[32'h1000] = 64'h5A5A_1111_2222_3333;
    mem[32'h1008] = 64'h4444_5555_6666_0077;
    // x also wraps through 0xFFFF here
    push_glyph(16'h5A5A, 16'hFFFE, 16'd7);
    push_glyph(16'h0077, 16'h0001, 16'd7);
    fetch_q.push_back(32'h1000);
    fetch_q.push_back(32'h1008);
    mem_delay = 2; blit_delay = 2;
    start_string(32'h1006, 16'd2, 16'hFFFE, 16'd7, 16'd3, 16'd0);
    wait_done(300);
    @(negedge clk); #1;
    total++;
    if (char_cnt - c0 != 2 || fetch_cnt - f0 != 2 || done_cnt - d0 != 1) begin
      bad++;
      $display("FAIL lane_counts: got chars %0d fetches %0d dones %0d required 2 2 1", char_cnt - c0, fetch_cnt - f0, done_cnt - d0);
    end
    total++;
    if (exp_q.size() != 0 || fetch_q.size() != 0) begin
      bad++;
      $display("FAIL lane_drain: got glyphs left %0d fetches left %0d required 0 0", exp_q.size(), fetch_q.size());
    end
  endtask

  task automatic test_zero_len;
    int c0, r0;
    c0 = char_cnt; r0 = req_cycles;
    start_string(32'h5000, 16'd0, 16'd1, 16'd1, 16'd1, 16'd1);
    #1;
    total++;
    if ({done, busy} !== 2'b01) begin
      bad++;
      $display("FAIL zero_cycle1: got done %b busy %b required 0 1", done, busy);
    end
    @(negedge clk); #1;
    total++;
    if ({done, busy} !== 2'b10) begin
      bad++;
      $display("FAIL zero_cycle2: got done %b busy %b required 1 0", done, busy);
    end
    @(negedge clk); #1;
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL zero_pulse: got done %b required 0", done);
    end
    repeat (5) @(negedge clk);
    #1;
    total++;
    if (req_cycles != r0 || char_cnt != c0) begin
      bad++;
      $display("FAIL zero_activity: got req cycles %0d chars %0d required 0 0", req_cycles - r0, char_cnt - c0);
    end
  endtask

  task automatic test_newline;
    int c0, d0, n_exp;
    c0 = char_cnt; d0 = done_cnt;
    mem[32'h2000] = 64'h0000_0042_000A_0041;
    fetch_q.push_back(32'h2000);
`ifdef GFX_TEXTSEQ_NEWLINE_EN
    push_glyph(16'h41, 16'd5, 16'd0);
    push_glyph(16'h42, 16'd5, 16'd12);
    n_exp = 2;
`else
    push_glyph(16'h41, 16'd5, 16'd0);
    push_glyph(16'h0A, 16'd13, 16'd0);
    push_glyph(16'h42, 16'd21, 16'd0);
    n_exp = 3;
`endif
    mem_delay = 1; blit_delay = 1;
    start_string(32'h2000, 16'd3, 16'd5, 16'd0, 16'd8, 16'd12);
    wait_done(300);
    @(negedge clk); #1;
    total++;
    if (char_cnt - c0 != n_exp || done_cnt - d0 != 1 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL newline_counts: got chars %0d dones %0d left %0d required %0d 1 0", char_cnt - c0, done_cnt - d0, exp_q.size(), n_exp);
    end
  endtask

  task automatic test_reset_mid;
    int c0, d0;
    c0 = char_cnt; d0 = done_cnt;
    mem[32'h3000] = 64'h0000_0063_0062_0061;
    push_glyph(16'h61, 16'd1, 16'd2);
    fetch_q.push_back(32'h3000);
    mem_delay = 1; blit_delay = 6;
    start_string(32'h3000, 16'd3, 16'd1, 16'd2, 16'd1, 16'd0);
    for (int i = 0; i < 50 && char_cnt == c0; i++) begin
      @(negedge clk);
      #1;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if ({busy, done, read_request, char_v} !== 4'b0 || {seq_sel, seq_adr} !== 40'd0) begin
      bad++;
      $display("FAIL midrst_ctrl: got %b sel %02h adr %08h required 0", {busy, done, read_request, char_v}, seq_sel, seq_adr);
    end
    total++;
    if ({char_code, char_pos_x, char_pos_y} !== 48'd0) begin
      bad++;
      $display("FAIL midrst_char: got %012h required 0", {char_code, char_pos_x, char_pos_y});
    end
    repeat (20) @(negedge clk);
    #1;
    total++;
    if (char_cnt - c0 != 1 || done_cnt != d0 || busy !== 1'b0 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL midrst_resume: got chars %0d dones %0d busy %b left %0d required 1 0 0 0", char_cnt - c0, done_cnt - d0, busy, exp_q.size());
    end
    blit_delay = 0;
  endtask

  task automatic test_back_to_back;
    int c0, f0, d0;
    c0 = char_cnt; f0 = fetch_cnt; d0 = done_cnt;
    adr_moved = 1'b0; hold_err = 1'b0;
    mem[32'h4000] = 64'h0000_0000_0072_0071;
    mem[32'h6000] = 64'h0000_0000_0000_0099;
    push_glyph(16'h71, 16'h20, 16'h30);
    push_glyph(16'h72, 16'h24, 16'h30);
    fetch_q.push_back(32'h4000);
    mem_delay = 5; blit_delay = 3;
    start_string(32'h4000, 16'd2, 16'h20, 16'h30, 16'd4, 16'd0);
    repeat (2) @(negedge clk);
    start_string(32'h6000, 16'd1, 16'h0, 16'h0, 16'd4, 16'd0);
    wait_done(300);
    repeat (10) @(negedge clk);
    #1;
    total++;
    if (done_cnt - d0 != 1 || char_cnt - c0 != 2 || fetch_cnt - f0 != 1) begin
      bad++;
      $display("FAIL b2b_counts: got dones %0d chars %0d fetches %0d required 1 2 1", done_cnt - d0, char_cnt - c0, fetch_cnt - f0);
    end
    total++;
    if (adr_moved !== 1'b0 || hold_err !== 1'b0) begin
      bad++;
      $display("FAIL b2b_stable: got adr moved %b char hold lost %b required 0 0", adr_moved, hold_err);
    end
    total++;
    if (exp_q.size() != 0 || fetch_q.size() != 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL b2b_drain: got glyphs left %0d fetches left %0d busy %b required 0 0 0", exp_q.size(), fetch_q.size(), busy);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    str_adr = '0; str_len = '0;
    pos_x = '0; pos_y = '0; adv_x = '0; adv_y = '0;
    test_reset;
    test_basic;
    test_lane_wrap;
    test_zero_len;
    test_newline;
    test_reset_mid;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
